// File: rtl/mem_copy_engine_pkg.sv
// Shared definitions for the memory copy engine.
//   ADDR_W / DATA_W / LEN_W : default widths for a 16K x 16 RAM
//   state_e                 : 2-bit FSM encoding
package mem_copy_engine_pkg;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_e;
endpackage

// File: rtl/copy_addr_counter.sv
// Loadable wrapping word pointer.
//   clk, rst  : clock, synchronous active-high reset (clears to 0)
//   load      : load load_val (wins over inc)
//   inc       : advance by one, wrapping modulo 2^W
//   value     : current pointer
module copy_addr_counter #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] value
);
  logic [W-1:0] val_q;

  always_ff @(posedge clk) begin
    if (rst)       val_q <= '0;
    else if (load) val_q <= load_val;
    else if (inc)  val_q <= val_q + W'(1);  // natural wrap at 2^W
  end

  assign value = val_q;
endmodule

// File: rtl/mem_copy_engine.sv
// Word-by-word RAM-to-RAM copy engine: one read cycle followed by one write
// cycle per word, strictly ascending addresses.
//   clk, re            : clock, synchronous active-high reset
//   start/src/dst/len  : copy request, sampled only while idle
//   busy, done, count  : status; done is a one-cycle pulse
//   m_e/m_r/m_w/m_addr/m_din/m_dout : single-port RAM interface, read data
//                        arrives combinationally in the read cycle
module mem_copy_engine #(
  parameter int ADDR_W = mem_copy_engine_pkg::ADDR_W,
  parameter int DATA_W = mem_copy_engine_pkg::DATA_W,
  parameter int LEN_W  = mem_copy_engine_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              re,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  count,
  output logic              m_e,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_w,
  output logic              m_r,
  output logic [DATA_W-1:0] m_din,
  input  logic [DATA_W-1:0] m_dout
);
  import mem_copy_engine_pkg::*;

  state_e              state_q;
  logic [LEN_W-1:0]    rem_q, cnt_q;
  logic [DATA_W-1:0]   hold_q;
  logic [ADDR_W-1:0]   m_addr_q;
  logic                m_e_q, m_r_q, m_w_q, busy_q, done_q;
  logic [ADDR_W-1:0]   rptr, wptr;
  logic                accept;

  assign accept = (state_q == ST_IDLE) && start;

  copy_addr_counter #(.W(ADDR_W)) u_rptr (
    .clk(clk), .rst(re), .load(accept), .load_val(src),
    .inc(state_q == ST_RD), .value(rptr)
  );

  copy_addr_counter #(.W(ADDR_W)) u_wptr (
    .clk(clk), .rst(re), .load(accept), .load_val(dst),
    .inc(state_q == ST_WR), .value(wptr)
  );

  // Outputs are registered from the state being entered, so the strobes and
  // address line up with RD/WR. On WR->RD the read pointer has already been
  // advanced by the previous RD edge; on IDLE->RD it is not loaded yet, so src
  // is used directly.
  always_ff @(posedge clk) begin
    if (re) begin
      state_q  <= ST_IDLE;
      rem_q    <= '0;
      cnt_q    <= '0;
      hold_q   <= '0;
      m_addr_q <= '0;
      m_e_q    <= 1'b0;
      m_r_q    <= 1'b0;
      m_w_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      m_e_q  <= 1'b0;
      m_r_q  <= 1'b0;
      m_w_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (start) begin
          rem_q  <= len;
          cnt_q  <= '0;
          busy_q <= 1'b1;
          if (len != '0) begin
            state_q  <= ST_RD;
            m_e_q    <= 1'b1;
            m_r_q    <= 1'b1;
            m_addr_q <= src;
          end else begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_RD: begin
          hold_q   <= m_dout;
          state_q  <= ST_WR;
          m_e_q    <= 1'b1;
          m_w_q    <= 1'b1;
          m_addr_q <= wptr;
        end
        ST_WR: begin
          cnt_q <= cnt_q + LEN_W'(1);
          rem_q <= rem_q - LEN_W'(1);
          if (rem_q != LEN_W'(1)) begin
            state_q  <= ST_RD;
            m_e_q    <= 1'b1;
            m_r_q    <= 1'b1;
            m_addr_q <= rptr;
          end else begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign count  = cnt_q;
  assign m_e    = m_e_q;
  assign m_r    = m_r_q;
  assign m_w    = m_w_q;
  assign m_addr = m_addr_q;
  assign m_din  = hold_q;
endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 Parameter ADDR_W, default 14, SHALL set the word address width, matching the 16K-word RAM.
REQ-002 Parameter DATA_W, default 16, SHALL set the data word width.
REQ-003 Parameter LEN_W, default 15, SHALL set the transfer length width, covering 0..16384 words.
REQ-004 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 re  in  1  SHALL be the reset: synchronous, active-high.
REQ-006 start  in  1  SHALL request a copy; sampled only in IDLE.
REQ-007 src  in  ADDR_W  SHALL be the first source word address; sampled with start.
REQ-008 dst  in  ADDR_W  SHALL be the first destination word address; sampled with start.
REQ-009 len  in  LEN_W  SHALL be the word count; sampled with start.
REQ-010 busy  out  1  SHALL be high in every state except IDLE.
REQ-011 done  out  1  SHALL be a one-cycle completion pulse.
REQ-012 count  out  LEN_W  SHALL give the number of words written so far in the current or last transfer.
REQ-013 m_e  out  1  SHALL be the RAM enable (chip select).
REQ-014 m_addr  out  ADDR_W  SHALL be the RAM word address.
REQ-015 m_w  out  1  SHALL be the RAM write strobe.
REQ-016 m_r  out  1  SHALL be the RAM read strobe.
REQ-017 m_din  out  DATA_W  SHALL be the write data to the RAM.
REQ-018 m_dout  in  DATA_W  SHALL be the RAM read data, valid combinationally in the same cycle as m_e&m_r.

Function
REQ-019 The FSM SHALL have exactly the states IDLE, RD, WR and DONE.
REQ-020 IDLE SHALL move to RD when start=1 and len!=0; to DONE when start=1 and len=0; otherwise stay in IDLE.
REQ-021 On start accept, the engine SHALL latch src into rptr, dst into wptr and len into remaining, and SHALL clear count.
REQ-022 In RD, the engine SHALL drive m_e=1, m_r=1, m_w=0, m_addr=rptr, capture m_dout into hold at the edge, increment rptr, and go to WR.
REQ-023 In WR, the engine SHALL drive m_e=1, m_w=1, m_r=0, m_addr=wptr, m_din=hold; at the edge it SHALL increment wptr and count and decrement remaining.
REQ-024 WR SHALL go to RD if remaining after decrement is nonzero, else to DONE.
REQ-025 DONE SHALL assert done=1 for one cycle and then return to IDLE.
REQ-026 In IDLE and DONE, m_e, m_r and m_w SHALL be 0, and m_addr/m_din SHALL hold their last values.
REQ-027 m_r and m_w SHALL never be high in the same cycle.
REQ-028 Address pointers SHALL increment modulo 2^ADDR_W, so 16383 wraps to 0.
REQ-029 Latency: for len=N>0 accepted at edge T0, done SHALL be high in cycle T0+2N+1, with exactly N reads and N writes.
REQ-030 For len=0, done SHALL be high in cycle T0+1 with no memory access.
REQ-031 start while busy SHALL be ignored without affecting the transfer in progress.
REQ-032 Copy order SHALL be strictly ascending, read-before-write per word; overlapping regions SHALL give the result of that sequential order.
REQ-033 len above 2^ADDR_W SHALL be processed literally, with addresses wrapping.

Reset
REQ-034 re=1 at an edge SHALL force IDLE, busy=0, done=0, count=0, m_e=m_r=m_w=0, m_addr=0, m_din=0, hold=0.
REQ-035 re asserted mid-transfer SHALL abort with no further RAM write; a write strobed in the same cycle as re SHALL still complete at the RAM, and done SHALL not pulse.
REQ-036 re SHALL take priority over start.

Structure
REQ-037 A shared package SHALL hold ADDR_W, DATA_W, LEN_W and the 2-bit state encoding (IDLE=0, RD=1, WR=2, DONE=3).
REQ-038 One sub-module, copy_addr_counter, SHALL implement a loadable wrapping ADDR_W-bit pointer (load, inc, value), instantiated twice for rptr and wptr.

Verification
REQ-039 The bench SHALL cover this scenario: RAM[100..103]=A,B,C,D; start src=100 dst=200 len=4 -> RAM[200..203]=A,B,C,D, done at T0+9, count=4.
REQ-040 The bench SHALL cover this scenario: len=0, src=5, dst=6 -> done at T0+1, m_e never high, RAM unchanged.
REQ-041 The bench SHALL cover this scenario: src=16382 dst=10 len=3 -> reads 16382, 16383, 0; writes 10..12.
REQ-042 The bench SHALL cover this scenario: overlap src=0 dst=1 len=3 with RAM[0]=X -> RAM[1..3]=X.
REQ-043 The bench SHALL cover this scenario: re pulsed on cycle T0+4 of a len=8 copy -> IDLE next cycle, exactly 2 words written, no done pulse.
REQ-044 The bench SHALL cover this scenario: second start during busy -> ignored, and the first copy completes with the original count.
